// File: rtl/sseg_p2s.sv
`default_nettype none
// ============================================================================
// Module   : sseg_p2s
// Brief    : 64-bit parallel-to-serial driver for a 74HC595 segment chain,
//            MSB first, with storage latch pulse and done strobe.
// Revision : 1.0 - initial release
// ============================================================================
module sseg_p2s #(
    parameter int DIV   = 2,
    parameter int NBITS = 64
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [NBITS-1:0] par_data,
    output logic             sclk,
    output logic             sout,
    output logic             slatch,
    output logic             busy,
    output logic             done
);

    localparam logic [2:0] c_IDLE     = 3'd0;
    localparam logic [2:0] c_SHIFT_LO = 3'd1;
    localparam logic [2:0] c_SHIFT_HI = 3'd2;
    localparam logic [2:0] c_LATCH    = 3'd3;
    localparam logic [2:0] c_DONE     = 3'd4;

    localparam logic [7:0] c_DIV_LAST = 8'(DIV - 1);
    localparam logic [5:0] c_BIT_LAST = 6'(NBITS - 1);

    logic [2:0]       r_state;
    logic [NBITS-1:0] r_shreg;
    logic [5:0]       r_bitcnt;
    logic [7:0]       r_divcnt;

    logic [2:0]       w_next_state;
    logic [NBITS-1:0] w_next_shreg;
    logic [5:0]       w_next_bitcnt;
    logic [7:0]       w_next_divcnt;
    logic             w_div_last;

    assign w_div_last = (r_divcnt == c_DIV_LAST);

    always_comb begin
        w_next_state  = c_IDLE;
        w_next_shreg  = r_shreg;
        w_next_bitcnt = r_bitcnt;
        w_next_divcnt = r_divcnt;
        case (r_state)
            c_IDLE: begin
                if (start) begin
                    w_next_state  = c_SHIFT_LO;
                    w_next_shreg  = par_data;
                    w_next_bitcnt = 6'd0;
                    w_next_divcnt = 8'd0;
                end
            end
            c_SHIFT_LO: begin
                if (w_div_last) begin
                    w_next_state  = c_SHIFT_HI;
                    w_next_divcnt = 8'd0;
                end else begin
                    w_next_state  = c_SHIFT_LO;
                    w_next_divcnt = r_divcnt + 8'd1;
                end
            end
            c_SHIFT_HI: begin
                if (w_div_last) begin
                    w_next_divcnt = 8'd0;
                    w_next_shreg  = {r_shreg[NBITS-2:0], 1'b0};
                    // bitcnt holds at its last value rather than wrapping
                    if (r_bitcnt == c_BIT_LAST) begin
                        w_next_state = c_LATCH;
                    end else begin
                        w_next_state  = c_SHIFT_LO;
                        w_next_bitcnt = r_bitcnt + 6'd1;
                    end
                end else begin
                    w_next_state  = c_SHIFT_HI;
                    w_next_divcnt = r_divcnt + 8'd1;
                end
            end
            c_LATCH: begin
                if (w_div_last) begin
                    w_next_state  = c_DONE;
                    w_next_divcnt = 8'd0;
                end else begin
                    w_next_state  = c_LATCH;
                    w_next_divcnt = r_divcnt + 8'd1;
                end
            end
            c_DONE:  w_next_state = c_IDLE;
            default: w_next_state = c_IDLE;
        endcase
    end

    // Outputs are registered from the next-state decode so each pin is a flop.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= c_IDLE;
            r_shreg  <= '0;
            r_bitcnt <= 6'd0;
            r_divcnt <= 8'd0;
            sclk     <= 1'b0;
            sout     <= 1'b0;
            slatch   <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
        end else begin
            r_state  <= w_next_state;
            r_shreg  <= w_next_shreg;
            r_bitcnt <= w_next_bitcnt;
            r_divcnt <= w_next_divcnt;
            sclk     <= (w_next_state == c_SHIFT_HI);
            sout     <= ((w_next_state == c_SHIFT_LO) || (w_next_state == c_SHIFT_HI))
                        & w_next_shreg[NBITS-1];
            slatch   <= (w_next_state == c_LATCH);
            busy     <= (w_next_state != c_IDLE);
            done     <= (w_next_state == c_DONE);
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_sseg_p2s.sv
`default_nettype none
// ============================================================================
// Module   : tb_sseg_p2s
// Brief    : Directed self-checking bench for sseg_p2s with a 74HC595 model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_sseg_p2s;

    logic        clk;
    logic        rst_n;
    logic        start, start1;
    logic [63:0] par, par1;
    logic        sclk, sout, slatch, busy, done;
    logic        sclk1, sout1, slatch1, busy1, done1;

    int checks;
    int errors;

    sseg_p2s #(.DIV(2), .NBITS(64)) u_dut (
        .clk(clk), .rst_n(rst_n), .start(start), .par_data(par),
        .sclk(sclk), .sout(sout), .slatch(slatch), .busy(busy), .done(done)
    );

    sseg_p2s #(.DIV(1), .NBITS(64)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .start(start1), .par_data(par1),
        .sclk(sclk1), .sout(sout1), .slatch(slatch1), .busy(busy1), .done(done1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Receiver model of the 74HC595 chain, sampled on the falling clk edge
    logic [63:0] rx_shift, rx_latch, rx1_shift, rx1_latch;
    logic        p_sclk, p_sout, p_slatch, p1_sclk, p1_slatch;
    int          rises, latches, slatch_cyc, dones, sout_viol, rises1, latches1;

    initial begin
        rx_shift = '0; rx_latch = '0; rx1_shift = '0; rx1_latch = '0;
        p_sclk = 0; p_sout = 0; p_slatch = 0; p1_sclk = 0; p1_slatch = 0;
        rises = 0; latches = 0; slatch_cyc = 0; dones = 0; sout_viol = 0;
        rises1 = 0; latches1 = 0;
    end

    always @(negedge clk) begin
        if (sclk && !p_sclk) begin
            rx_shift = {rx_shift[62:0], sout};
            rises++;
        end
        if (sclk && p_sclk && (sout !== p_sout)) sout_viol++;
        if (slatch && !p_slatch) begin
            rx_latch = rx_shift;
            latches++;
        end
        if (slatch) slatch_cyc++;
        if (done) dones++;
        p_sclk = sclk; p_sout = sout; p_slatch = slatch;
        if (sclk1 && !p1_sclk) begin
            rx1_shift = {rx1_shift[62:0], sout1};
            rises1++;
        end
        if (slatch1 && !p1_slatch) begin
            rx1_latch = rx1_shift;
            latches1++;
        end
        p1_sclk = sclk1; p1_slatch = slatch1;
    end

    task automatic pulse_start(input logic [63:0] d);
        @(posedge clk); #1 start = 1'b1; par = d;
        @(posedge clk); #1 start = 1'b0;
        @(negedge clk);
    endtask

    // Runs from a falling edge until busy drops; returns busy cycles and done index
    task automatic measure(output int len, output int done_idx);
        int n;
        n = 0;
        done_idx = -1;
        while (busy && n < 2000) begin
            if (done) done_idx = n;
            n++;
            @(negedge clk);
        end
        len = n;
    endtask

    task automatic test_reset;
        rst_n = 1'b0; start = 1'b1; start1 = 1'b1; par = '1; par1 = '1;
        repeat (3) @(negedge clk);
        checks++;
        if ({sclk, sout, slatch, busy, done} !== 5'b0) begin
            errors++;
            $display("FAIL reset_outs: got %b required 00000", {sclk, sout, slatch, busy, done});
        end
        checks++;
        if ({sclk1, sout1, slatch1, busy1, done1} !== 5'b0) begin
            errors++;
            $display("FAIL reset_outs_div1: got %b required 00000", {sclk1, sout1, slatch1, busy1, done1});
        end
        start = 1'b0; start1 = 1'b0;
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if ({sclk, sout, slatch, busy, done} !== 5'b0) begin
            errors++;
            $display("FAIL idle_outs: got %b required 00000", {sclk, sout, slatch, busy, done});
        end
    endtask

    task automatic test_basic_frame;
        int b_r, b_l, b_s, b_d, b_v, len, idx;
        b_r = rises; b_l = latches; b_s = slatch_cyc; b_d = dones; b_v = sout_viol;
        pulse_start(64'h8000_0000_0000_0001);
        measure(len, idx);
        repeat (3) @(negedge clk);
        checks++;
        if (rx_latch !== 64'h8000_0000_0000_0001) begin
            errors++;
            $display("FAIL basic_latch: got %h required 8000000000000001", rx_latch);
        end
        checks++;
        if (rises - b_r !== 64) begin
            errors++;
            $display("FAIL basic_rises: got %0d required 64", rises - b_r);
        end
        checks++;
        if (latches - b_l !== 1) begin
            errors++;
            $display("FAIL basic_latches: got %0d required 1", latches - b_l);
        end
        checks++;
        if (slatch_cyc - b_s !== 2) begin
            errors++;
            $display("FAIL basic_slatch_len: got %0d required 2", slatch_cyc - b_s);
        end
        checks++;
        if (idx !== 258) begin
            errors++;
            $display("FAIL basic_done_idx: got %0d required 258", idx);
        end
        checks++;
        if (len !== 259) begin
            errors++;
            $display("FAIL basic_busy_len: got %0d required 259", len);
        end
        checks++;
        if (dones - b_d !== 1) begin
            errors++;
            $display("FAIL basic_dones: got %0d required 1", dones - b_d);
        end
        checks++;
        if (sout_viol - b_v !== 0) begin
            errors++;
            $display("FAIL basic_sout_stable: got %0d changes required 0", sout_viol - b_v);
        end
    endtask

    task automatic test_ignore_start;
        int b_r, b_l, b_d, len, idx, n;
        b_r = rises; b_l = latches; b_d = dones;
        pulse_start(64'hA5A5_0000_FFFF_1234);
        n = 0;
        while ((rises - b_r) < 20 && n < 500) begin
            n++;
            @(negedge clk);
        end
        @(posedge clk); #1 start = 1'b1; par = '0;
        @(posedge clk); #1 start = 1'b0;
        @(negedge clk);
        measure(len, idx);
        repeat (4) @(negedge clk);
        checks++;
        if (rx_latch !== 64'hA5A5_0000_FFFF_1234) begin
            errors++;
            $display("FAIL ignore_latch: got %h required a5a50000ffff1234", rx_latch);
        end
        checks++;
        if (dones - b_d !== 1) begin
            errors++;
            $display("FAIL ignore_dones: got %0d required 1", dones - b_d);
        end
        checks++;
        if (latches - b_l !== 1) begin
            errors++;
            $display("FAIL ignore_latches: got %0d required 1", latches - b_l);
        end
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL ignore_not_queued: busy %b required 0", busy);
        end
    endtask

    task automatic test_reset_abort;
        int b_r, b_l, len, idx, n;
        b_r = rises;
        pulse_start(64'hFFFF_0000_FFFF_0000);
        n = 0;
        while ((rises - b_r) < 20 && n < 500) begin
            n++;
            @(negedge clk);
        end
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL abort_busy_before: got %b required 1", busy);
        end
        b_l = latches;
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({sclk, sout, slatch, busy, done} !== 5'b0) begin
            errors++;
            $display("FAIL abort_async_outs: got %b required 00000", {sclk, sout, slatch, busy, done});
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if (latches - b_l !== 0) begin
            errors++;
            $display("FAIL abort_no_latch: got %0d pulses required 0", latches - b_l);
        end
        b_r = rises; b_l = latches;
        pulse_start(64'h0123_4567_89AB_CDEF);
        measure(len, idx);
        repeat (3) @(negedge clk);
        checks++;
        if (rx_latch !== 64'h0123_4567_89AB_CDEF) begin
            errors++;
            $display("FAIL abort_next_latch: got %h required 0123456789abcdef", rx_latch);
        end
        checks++;
        if (rises - b_r !== 64 || latches - b_l !== 1) begin
            errors++;
            $display("FAIL abort_next_counts: got %0d rises %0d latches required 64 1", rises - b_r, latches - b_l);
        end
        checks++;
        if (len !== 259) begin
            errors++;
            $display("FAIL abort_next_busy_len: got %0d required 259", len);
        end
    endtask

    task automatic test_back_to_back;
        int b_l, b_d, len, idx, n;
        logic [63:0] first;
        b_l = latches; b_d = dones;
        @(posedge clk); #1 start = 1'b1; par = 64'h3C3C_F00F_1357_9BDF;
        @(posedge clk); #1;
        @(negedge clk);
        measure(len, idx);
        first = rx_latch;
        n = 0;
        while (!busy && n < 10) begin
            n++;
            @(negedge clk);
        end
        checks++;
        if (len !== 259) begin
            errors++;
            $display("FAIL b2b_busy_len: got %0d required 259", len);
        end
        checks++;
        if (n !== 1) begin
            errors++;
            $display("FAIL b2b_idle_gap: got %0d required 1", n);
        end
        @(posedge clk); #1 start = 1'b0;
        @(negedge clk);
        measure(len, idx);
        repeat (4) @(negedge clk);
        checks++;
        if (first !== 64'h3C3C_F00F_1357_9BDF) begin
            errors++;
            $display("FAIL b2b_first: got %h required 3c3cf00f13579bdf", first);
        end
        checks++;
        if (rx_latch !== 64'h3C3C_F00F_1357_9BDF) begin
            errors++;
            $display("FAIL b2b_second: got %h required 3c3cf00f13579bdf", rx_latch);
        end
        checks++;
        if (latches - b_l !== 2) begin
            errors++;
            $display("FAIL b2b_latches: got %0d required 2", latches - b_l);
        end
        checks++;
        if (dones - b_d !== 2) begin
            errors++;
            $display("FAIL b2b_dones: got %0d required 2", dones - b_d);
        end
    endtask

    task automatic test_div1;
        int b_r, b_l, n, idx, tog_err, sout_err;
        b_r = rises1; b_l = latches1;
        @(posedge clk); #1 start1 = 1'b1; par1 = '1;
        @(posedge clk); #1 start1 = 1'b0;
        @(negedge clk);
        n = 0; idx = -1; tog_err = 0; sout_err = 0;
        while (busy1 && n < 1000) begin
            if (n < 128) begin
                if (sclk1 !== n[0]) tog_err++;
                if (sout1 !== 1'b1) sout_err++;
            end
            if (done1) idx = n;
            n++;
            @(negedge clk);
        end
        repeat (3) @(negedge clk);
        checks++;
        if (n !== 130) begin
            errors++;
            $display("FAIL div1_busy_len: got %0d required 130", n);
        end
        checks++;
        if (idx !== 129) begin
            errors++;
            $display("FAIL div1_done_idx: got %0d required 129", idx);
        end
        checks++;
        if (tog_err !== 0 || sout_err !== 0) begin
            errors++;
            $display("FAIL div1_toggle: got %0d sclk and %0d sout errors required 0 0", tog_err, sout_err);
        end
        checks++;
        if (rises1 - b_r !== 64) begin
            errors++;
            $display("FAIL div1_rises: got %0d required 64", rises1 - b_r);
        end
        checks++;
        if (rx1_latch !== 64'hFFFF_FFFF_FFFF_FFFF || latches1 - b_l !== 1) begin
            errors++;
            $display("FAIL div1_latch: got %h x%0d required ffffffffffffffff x1", rx1_latch, latches1 - b_l);
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_basic_frame();
        test_ignore_start();
        test_reset_abort();
        test_back_to_back();
        test_div1();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/sseg_p2s.md
SSEG_P2S -- requirements
Module: sseg_p2s

Interface
REQ-001 Parameter DIV, default 2: half-period of sclk in clk cycles; legal range 1..255.
REQ-002 Parameter NBITS, default 64: frame length in bits; fixed at 64 for this board, other values unsupported.
REQ-003 clk  input  1  system clock; all flops on rising edge.
REQ-004 rst_n  input  1  reset; one clock; reset is asynchronous and active-low.
REQ-005 start  input  1  frame request; level-sampled only in IDLE.
REQ-006 par_data  input  64  segment map frame (bit 63 = farthest 74HC595 bit).
REQ-007 sclk  output  1  shift clock to 74HC595 chain; data sampled by chain on its rising edge.
REQ-008 sout  output  1  serial data to chain.
REQ-009 slatch  output  1  storage-register latch; chain transfers on its rising edge.
REQ-010 busy  output  1  high from frame capture until the end of DONE.
REQ-011 done  output  1  one-cycle pulse at frame completion.

Function
REQ-012 States: IDLE, SHIFT_LO, SHIFT_HI, LATCH, DONE; internal 64-bit shift register shreg, 6-bit bit counter bitcnt, 8-bit divider counter divcnt.
REQ-013 All five outputs shall be driven directly from flops (registered or one-hot state bits), never from combinational decode; no glitches on sclk or slatch.
REQ-014 IDLE: sclk=0, sout=0, slatch=0, busy=0, done=0.
REQ-015 IDLE with start=1 at a clk edge: shreg<=par_data, bitcnt<=0, divcnt<=0, next state SHIFT_LO; busy=1 from that edge.
REQ-016 SHIFT_LO: sclk=0, sout=shreg[63]; after DIV cycles (divcnt==DIV-1), go to SHIFT_HI and clear divcnt.
REQ-017 SHIFT_HI: sclk=1, sout held stable; after DIV cycles, shreg<<=1 (zero fill), bitcnt+=1; go to LATCH if bitcnt was 63, else SHIFT_LO.
REQ-018 Transmission order MSB first: par_data[63] is the first bit out and par_data[0] the last.
REQ-019 Exactly 64 sclk rising edges per frame; sout never changes while sclk=1.
REQ-020 LATCH: sclk=0, sout=0, slatch=1 for DIV cycles, then DONE.
REQ-021 DONE: slatch=0, busy=1, done=1 for exactly one cycle, then IDLE.
REQ-022 busy stays high for 128*DIV + DIV + 1 consecutive cycles per frame.
REQ-023 start while busy=1 shall be ignored and not queued; par_data changes after capture shall not affect the frame in flight.
REQ-024 start held high continuously: the next frame is captured on the first IDLE edge after DONE (one IDLE cycle between frames).
REQ-025 bitcnt and divcnt shall not wrap or overflow within a frame; no state other than the five listed is reachable; any illegal encoding shall recover to IDLE on the next edge.

Reset
REQ-026 rst_n=0 shall asynchronously force state=IDLE, shreg=0, bitcnt=0, divcnt=0, sclk=0, sout=0, slatch=0, busy=0, done=0, including mid-frame.
REQ-027 A frame aborted by reset shall not produce a slatch pulse; the first start after rst_n rises shall send a complete 64-bit frame.

Verification (DIV=2 unless stated)
REQ-028 Reset: rst_n=0 asynchronously between clk edges -> all outputs 0 immediately, before the next clk edge.
REQ-029 par_data=64'h8000_0000_0000_0001, 1-cycle start -> sout=1 on bit 0, 0 on bits 1..62, 1 on bit 63; 64 sclk rises; slatch high 2 cycles; done high in cycle 258 after capture; busy high 259 cycles.
REQ-030 par_data=64'hA5A5_0000_FFFF_1234, start re-pulsed at bit 20 with par_data=0 -> captured bit stream equals the original frame exactly; only one done pulse.
REQ-031 rst_n pulsed low after 20 sclk rises -> no slatch pulse; after release, start with 64'h0123_4567_89AB_CDEF -> receiver model latches exactly 64'h0123_4567_89AB_CDEF.
REQ-032 start held high, two frames -> second capture on the edge after the one-cycle IDLE; receiver model shows two identical latched frames.
REQ-033 DIV=1, par_data=64'hFFFF_FFFF_FFFF_FFFF -> sclk toggles every cycle; busy high 130 cycles; done in cycle 129.
